// File: rtl/add_word_sequencer.sv
// Word-serial adder: reuses one N-bit full adder for WORDS clock cycles, LSW first,
// rippling the carry through a register, then reports sum, carry-out and signed overflow.

module full_add_n_bit #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c_in,
  output logic [N-1:0] sum,
  output logic         c_out
);
  assign {c_out, sum} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, c_in};
endmodule

module add_word_sequencer #(
  parameter int N     = 8,
  parameter int WORDS = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [N*WORDS-1:0]   a,
  input  logic [N*WORDS-1:0]   b,
  input  logic                 carry_in,
  output logic                 busy,
  output logic                 done,
  output logic [N*WORDS-1:0]   sum,
  output logic                 c_out,
  output logic                 ovf
);
  localparam int W  = N * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t          state, state_next;
  logic [W-1:0]    a_q, b_q, acc;
  logic            cy, ovf_q;
  logic [IW-1:0]   idx;
  logic [N-1:0]    word_a, word_b, word_sum;
  logic            word_cout;
  logic            last;

  assign word_a = a_q[idx*N +: N];
  assign word_b = b_q[idx*N +: N];
  assign last   = (idx == IW'(WORDS - 1));
  assign busy   = (state != IDLE);

  full_add_n_bit #(.N(N)) u_add (
    .a     (word_a),
    .b     (word_b),
    .c_in  (cy),
    .sum   (word_sum),
    .c_out (word_cout)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = ADD;
      ADD:     if (last)  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Control, carry and published results; outputs are copied from acc only once the
  // top word has landed, so sum/c_out/ovf never show partial values.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx   <= '0;
      cy    <= 1'b0;
      ovf_q <= 1'b0;
      sum   <= '0;
      c_out <= 1'b0;
      ovf   <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cy  <= carry_in;
            idx <= '0;
          end
        end
        ADD: begin
          cy <= word_cout;
          if (last) ovf_q <= (a_q[W-1] == b_q[W-1]) && (word_sum[N-1] != a_q[W-1]);
          else      idx   <= idx + 1'b1;
        end
        DONE: begin
          sum   <= acc;
          c_out <= cy;
          ovf   <= ovf_q;
          done  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Operand capture and partial-sum storage need no reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      a_q <= a;
      b_q <= b;
    end
    if (state == ADD) acc[idx*N +: N] <= word_sum;
  end
endmodule
